// File: rtl/sp_ram_pkg.sv
// Shared constants and helpers for the single-port RAM initiator slice.
package sp_ram_pkg;

    localparam int MAX_RAM_LATENCY = 4;

    // Bits needed to count 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sp_ram_rsp_fifo.sv
// First-word-fall-through response FIFO; head entry is visible whenever not empty.
module sp_ram_rsp_fifo
    import sp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]         rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]         count_reg, count_next;
    logic                  do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign head_data = mem_reg[rd_ptr_reg];

    // When full, a simultaneous pop frees the head slot that the push lands in.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (do_push) mem_reg[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            assert (!(push && full && !pop));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// Valid/ready front end for a single-port RAM: credit-gated requests, latency
// tracking, and in-order read responses through a small FWFT buffer.
module sp_ram_initiator
    import sp_ram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int RAM_LATENCY = 1,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  ReqValid_SI,
    output logic                  ReqReady_SO,
    input  logic                  ReqWrEn_SI,
    input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [DATA_WIDTH-1:0] ReqWrData_DI,
    output logic                  RspValid_SO,
    input  logic                  RspReady_SI,
    output logic [DATA_WIDTH-1:0] RspData_DO,
    output logic                  RamCSel_SO,
    output logic                  RamWrEn_SO,
    output logic [ADDR_WIDTH-1:0] RamAddr_DO,
    output logic [DATA_WIDTH-1:0] RamWrData_DO,
    input  logic [DATA_WIDTH-1:0] RamRdData_DI
);

    localparam int CW = cnt_width(RESP_DEPTH);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);

    logic [CW-1:0]        credit_reg, credit_next;
    logic [RAM_LATENCY:0] pipe_chain;
    logic                 req_accept, rd_accept, rsp_pop, rsp_push;
    logic                 fifo_full, fifo_empty;

    // A credit reserves one buffer slot for every read in the RAM pipeline, so
    // returning data always has somewhere to land regardless of backpressure.
    assign RspValid_SO = Rst_RBI & ~fifo_empty;
    assign rsp_pop     = RspValid_SO & RspReady_SI;
    assign ReqReady_SO = Rst_RBI & ((credit_reg != '0) | rsp_pop);
    assign req_accept  = ReqValid_SI & ReqReady_SO;
    assign rd_accept   = req_accept & ~ReqWrEn_SI;

    assign RamCSel_SO   = req_accept;
    assign RamWrEn_SO   = ReqWrEn_SI;
    assign RamAddr_DO   = ReqAddr_DI;
    assign RamWrData_DO = ReqWrData_DI;

    always_comb begin
        credit_next = credit_reg;
        case ({rd_accept, rsp_pop})
            2'b10:   credit_next = credit_reg - 1'b1;
            2'b01:   credit_next = credit_reg + 1'b1;
            default: credit_next = credit_reg;
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            credit_reg <= CREDIT_MAX;
        end else begin
            credit_reg <= credit_next;
        end
    end

    // Read-valid shift register matching the RAM's read latency.
    assign pipe_chain[0] = rd_accept;

    generate
        for (genvar gi = 0; gi < RAM_LATENCY; gi++) begin : g_lat
            logic stage_reg;
            always_ff @(posedge Clk_CI) begin
                if (!Rst_RBI) begin
                    stage_reg <= 1'b0;
                end else begin
                    stage_reg <= pipe_chain[gi];
                end
            end
            assign pipe_chain[gi+1] = stage_reg;
        end
    endgenerate

    assign rsp_push = pipe_chain[RAM_LATENCY];

    sp_ram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) i_rsp_fifo (
        .Clk_CI    (Clk_CI),
        .Rst_RBI   (Rst_RBI),
        .push      (rsp_push),
        .push_data (RamRdData_DI),
        .pop       (rsp_pop),
        .head_data (RspData_DO),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            assert (RAM_LATENCY >= 1 && RAM_LATENCY <= MAX_RAM_LATENCY);
            assert (credit_reg <= CREDIT_MAX);
            assert (!(rd_accept && !rsp_pop && credit_reg == '0));
            assert (!(rsp_push && fifo_full && !rsp_pop));
        end
    end

endmodule

// File: tb/tb_sp_ram_initiator.sv
// Directed bench for sp_ram_initiator with a scoreboard of expected read data,
// covering latency 1/depth 2 and latency 2/depth 3 configurations.
module tb_sp_ram_initiator;

    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Configuration A: latency 1, depth 2
    logic          a_req_valid = 0, a_wr_en = 0, a_rsp_ready = 1;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          a_req_ready, a_rsp_valid, a_csel, a_ram_we;
    logic [DW-1:0] a_rsp_data, a_ram_wdata, a_ram_rdata;
    logic [AW-1:0] a_ram_addr;

    // Configuration B: latency 2, depth 3
    logic          b_req_valid = 0, b_wr_en = 0, b_rsp_ready = 1;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          b_req_ready, b_rsp_valid, b_csel, b_ram_we;
    logic [DW-1:0] b_rsp_data, b_ram_wdata, b_ram_rdata, b_rd1;
    logic [AW-1:0] b_ram_addr;

    sp_ram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(1), .RESP_DEPTH(2)) dut_a (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(a_req_valid), .ReqReady_SO(a_req_ready), .ReqWrEn_SI(a_wr_en),
        .ReqAddr_DI(a_addr), .ReqWrData_DI(a_wdata),
        .RspValid_SO(a_rsp_valid), .RspReady_SI(a_rsp_ready), .RspData_DO(a_rsp_data),
        .RamCSel_SO(a_csel), .RamWrEn_SO(a_ram_we), .RamAddr_DO(a_ram_addr),
        .RamWrData_DO(a_ram_wdata), .RamRdData_DI(a_ram_rdata)
    );

    sp_ram_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(2), .RESP_DEPTH(3)) dut_b (
        .Clk_CI(clk), .Rst_RBI(rst_n),
        .ReqValid_SI(b_req_valid), .ReqReady_SO(b_req_ready), .ReqWrEn_SI(b_wr_en),
        .ReqAddr_DI(b_addr), .ReqWrData_DI(b_wdata),
        .RspValid_SO(b_rsp_valid), .RspReady_SI(b_rsp_ready), .RspData_DO(b_rsp_data),
        .RamCSel_SO(b_csel), .RamWrEn_SO(b_ram_we), .RamAddr_DO(b_ram_addr),
        .RamWrData_DO(b_ram_wdata), .RamRdData_DI(b_ram_rdata)
    );

    function automatic logic [DW-1:0] init_a(input int i);
        case (i)
            1:       return 32'h0000_0011;
            2:       return 32'h0000_0022;
            3:       return 32'h0000_0033;
            default: return 32'hA000_0000 | i;
        endcase
    endfunction

    function automatic logic [DW-1:0] init_b(input int i);
        if (i == 10) return 32'hCAFE_0001;
        return 32'hB000_0000 | i;
    endfunction

    // RAM models; contents are loaded on the first edge while reset is held.
    logic [DW-1:0] mem_a [1024];
    logic [DW-1:0] mem_b [1024];
    logic          mem_loaded = 1'b0;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= init_a(i);
                mem_b[i] <= init_b(i);
            end
            mem_loaded <= 1'b1;
        end else begin
            if (a_csel) begin
                if (a_ram_we) mem_a[a_ram_addr] <= a_ram_wdata;
                else          a_ram_rdata <= mem_a[a_ram_addr];
            end
            if (b_csel) begin
                if (b_ram_we) mem_b[b_ram_addr] <= b_ram_wdata;
                else          b_rd1 <= mem_b[b_ram_addr];
            end
            b_ram_rdata <= b_rd1;
        end
    end

    // Reference memories and scoreboards
    logic [DW-1:0] ref_a [1024];
    logic [DW-1:0] ref_b [1024];
    logic [DW-1:0] qa [$];
    logic [DW-1:0] qb [$];

    int a_csel_cnt = 0, a_rsp_cnt = 0, a_stall_cnt = 0, a_streak = 0, a_max_streak = 0;
    int b_csel_cnt = 0, b_rsp_cnt = 0, b_stall_cnt = 0, b_streak = 0, b_max_streak = 0;
    bit a_prev_stall = 0, b_prev_stall = 0;
    logic [DW-1:0] a_prev_data, b_prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            a_prev_stall = 0;
            a_streak = 0;
        end else begin
            if (a_prev_stall) begin
                check("a_hold_valid", a_rsp_valid, 1);
                check("a_hold_data", a_rsp_data, a_prev_data);
            end
            if (a_rsp_valid && a_rsp_ready) begin
                a_rsp_cnt++;
                a_streak++;
                if (a_streak > a_max_streak) a_max_streak = a_streak;
                check("a_rsp_expected", qa.size() != 0, 1);
                if (qa.size() != 0) check("a_rsp_data", a_rsp_data, qa.pop_front());
            end else begin
                a_streak = 0;
            end
            if (a_req_valid && !a_req_ready) a_stall_cnt++;
            if (a_req_valid && a_req_ready) begin
                if (a_wr_en) ref_a[a_addr] = a_wdata;
                else         qa.push_back(ref_a[a_addr]);
            end
            if (a_csel) a_csel_cnt++;
            a_prev_stall = a_rsp_valid && !a_rsp_ready;
            a_prev_data  = a_rsp_data;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
            b_prev_stall = 0;
            b_streak = 0;
        end else begin
            if (b_prev_stall) begin
                check("b_hold_valid", b_rsp_valid, 1);
                check("b_hold_data", b_rsp_data, b_prev_data);
            end
            if (b_rsp_valid && b_rsp_ready) begin
                b_rsp_cnt++;
                b_streak++;
                if (b_streak > b_max_streak) b_max_streak = b_streak;
                check("b_rsp_expected", qb.size() != 0, 1);
                if (qb.size() != 0) check("b_rsp_data", b_rsp_data, qb.pop_front());
            end else begin
                b_streak = 0;
            end
            if (b_req_valid && !b_req_ready) b_stall_cnt++;
            if (b_req_valid && b_req_ready) begin
                if (b_wr_en) ref_b[b_addr] = b_wdata;
                else         qb.push_back(ref_b[b_addr]);
            end
            if (b_csel) b_csel_cnt++;
            b_prev_stall = b_rsp_valid && !b_rsp_ready;
            b_prev_data  = b_rsp_data;
        end
    end

    task automatic send(input bit sel, input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bit ok = 0;
        if (sel) begin b_req_valid = 1; b_wr_en = we; b_addr = addr; b_wdata = data; end
        else     begin a_req_valid = 1; a_wr_en = we; a_addr = addr; a_wdata = data; end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = sel ? b_req_ready : a_req_ready;
        end
        check("send_accept", ok, 1);
        @(posedge clk); #1;
        if (sel) b_req_valid = 0; else a_req_valid = 0;
    endtask

    task automatic drain(input bit sel);
        bit done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            done = sel ? (qb.size() == 0 && !b_rsp_valid) : (qa.size() == 0 && !a_rsp_valid);
        end
        check(sel ? "b_drain" : "a_drain", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, r0, s0;
        for (int i = 0; i < 1024; i++) begin
            ref_a[i] = init_a(i);
            ref_b[i] = init_b(i);
        end

        // 1: reset holds everything quiet even with a pending request
        a_req_valid = 1;
        b_req_valid = 1;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_a_ready", a_req_ready, 0);
            check("rst_a_csel", a_csel, 0);
            check("rst_a_rspvalid", a_rsp_valid, 0);
            check("rst_b_ready", b_req_ready, 0);
            check("rst_b_csel", b_csel, 0);
        end
        @(posedge clk); #1;
        a_req_valid = 0;
        b_req_valid = 0;
        rst_n = 1;
        @(negedge clk);
        check("post_rst_a_ready", a_req_ready, 1);
        check("post_rst_b_ready", b_req_ready, 1);
        @(posedge clk); #1;

        // 2: write then read-after-write, response two cycles after accept
        c0 = a_csel_cnt;
        r0 = a_rsp_cnt;
        send(0, 1, 10'h005, 32'hDEAD_BEEF);
        send(0, 0, 10'h005, 32'h0);
        @(negedge clk);
        check("raw_rsp_early", a_rsp_valid, 0);
        @(negedge clk);
        check("raw_rsp_valid", a_rsp_valid, 1);
        check("raw_rsp_data", a_rsp_data, 32'hDEAD_BEEF);
        drain(0);
        check("raw_csel_pulses", a_csel_cnt - c0, 2);
        check("raw_rsp_count", a_rsp_cnt - r0, 1);

        // 3: backpressure exhausts credits; pop re-opens ready combinationally
        r0 = a_rsp_cnt;
        a_rsp_ready = 0;
        send(0, 0, 10'h001, 32'h0);
        send(0, 0, 10'h002, 32'h0);
        a_req_valid = 1; a_wr_en = 0; a_addr = 10'h003;
        @(negedge clk);
        check("bp_stall", a_req_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_stall2", a_req_ready, 0);
        check("bp_head_valid", a_rsp_valid, 1);
        check("bp_head_data", a_rsp_data, 32'h0000_0011);
        @(posedge clk); #1;
        a_rsp_ready = 1;
        @(negedge clk);
        check("bp_accept_on_pop", a_req_ready, 1);
        check("bp_pop_data", a_rsp_data, 32'h0000_0011);
        @(posedge clk); #1;
        a_req_valid = 0;
        drain(0);
        check("bp_rsp_count", a_rsp_cnt - r0, 3);

        // 4: streaming reads, no stall and back-to-back responses
        s0 = a_stall_cnt;
        r0 = a_rsp_cnt;
        a_max_streak = 0;
        for (int i = 0; i < 8; i++) send(0, 0, AW'(i), 32'h0);
        drain(0);
        check("stream_a_stalls", a_stall_cnt - s0, 0);
        check("stream_a_streak", a_max_streak, 8);
        check("stream_a_count", a_rsp_cnt - r0, 8);

        // 5: reset with reads in flight discards them and restores credits
        r0 = a_rsp_cnt;
        send(0, 0, 10'h001, 32'h0);
        send(0, 0, 10'h002, 32'h0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        repeat (10) begin @(posedge clk); #1; end
        check("midrst_no_rsp", a_rsp_cnt - r0, 0);
        a_rsp_ready = 0;
        send(0, 0, 10'h005, 32'h0);
        send(0, 0, 10'h006, 32'h0);
        a_req_valid = 1; a_wr_en = 0; a_addr = 10'h007;
        @(negedge clk);
        check("midrst_credits", a_req_ready, 0);
        check("midrst_data", a_rsp_data, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        a_rsp_ready = 1;
        @(posedge clk); #1;
        a_req_valid = 0;
        drain(0);
        check("midrst_rsp_count", a_rsp_cnt - r0, 3);

        // 6: latency-2 configuration
        r0 = b_rsp_cnt;
        send(1, 0, 10'h00A, 32'h0);
        @(negedge clk);
        check("lat2_early1", b_rsp_valid, 0);
        @(negedge clk);
        check("lat2_early2", b_rsp_valid, 0);
        @(negedge clk);
        check("lat2_valid", b_rsp_valid, 1);
        check("lat2_data", b_rsp_data, 32'hCAFE_0001);
        drain(1);
        s0 = b_stall_cnt;
        b_max_streak = 0;
        for (int i = 0; i < 10; i++) send(1, 0, AW'(16 + i), 32'h0);
        drain(1);
        check("stream_b_stalls", b_stall_cnt - s0, 0);
        check("stream_b_streak", b_max_streak, 10);
        check("stream_b_count", b_rsp_cnt - r0, 11);
        check("b_csel_pulses", b_csel_cnt, 11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sp_ram_initiator.md
Name: sp_ram_initiator

Overview:
- Initiator-side port controller for a synchronous single-port RAM: converts a valid/ready request channel into RAM chip-select/write-enable cycles.
- Tracks read latency and returns read data on a valid/ready response channel, in order.
- Credit-based flow control guarantees no read data is lost under response backpressure.
- Sits between any master (DMA, TLB walker, test engine) and the team's inferable single-port RAM.

Parameters:
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 32, RAM word width
- RAM_LATENCY, 1, read latency of the attached RAM in cycles (1 + its output-register count); legal values 1..4
- RESP_DEPTH, 2, response buffer entries; must be >= RAM_LATENCY+1 for full throughput, >= 1 always

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset, synchronous active-low
- ReqValid_SI  in  1  request valid
- ReqReady_SO  out  1  request ready
- ReqWrEn_SI  in  1  1 = write, 0 = read
- ReqAddr_DI  in  ADDR_WIDTH  request address
- ReqWrData_DI  in  DATA_WIDTH  write data
- RspValid_SO  out  1  read response valid
- RspReady_SI  in  1  read response ready
- RspData_DO  out  DATA_WIDTH  read data
- RamCSel_SO  out  1  RAM chip select
- RamWrEn_SO  out  1  RAM write enable
- RamAddr_DO  out  ADDR_WIDTH  RAM address
- RamWrData_DO  out  DATA_WIDTH  RAM write data
- RamRdData_DI  in  DATA_WIDTH  RAM read data

Behaviour:
- One clock (Clk_CI). Reset is synchronous and active-low (Rst_RBI). All state is cleared on a clock edge with Rst_RBI=0.
- Reset state:
  - credits = RESP_DEPTH; latency pipe all 0; response FIFO empty.
  - While Rst_RBI=0: ReqReady_SO=0, RamCSel_SO=0, RspValid_SO=0.
- Acceptance: accept = ReqValid_SI & ReqReady_SO.
- RAM drive (combinational pass-through):
  - RamCSel_SO = accept; RamWrEn_SO = ReqWrEn_SI.
  - RamAddr_DO = ReqAddr_DI; RamWrData_DO = ReqWrData_DI.
  - The RAM samples on the same edge as acceptance.
- Ready rule: ReqReady_SO = (credits > 0) | pop, where pop = RspValid_SO & RspReady_SI.
  - ReqReady_SO does not depend on ReqWrEn_SI; writes also require ReqReady_SO.
  - The combinational path RspReady_SI -> ReqReady_SO is intentional.
- Credits (width $clog2(RESP_DEPTH+1)):
  - Decrement on a read accept; increment on pop; unchanged when both occur in the same cycle.
  - Never exceeds RESP_DEPTH, never underflows (assertion).
  - Writes consume no credit and produce no response.
- Latency pipe:
  - RAM_LATENCY-deep shift register of valid bits; stage 0 is loaded with (accept & ~ReqWrEn_SI).
  - When the last stage is 1, RamRdData_DI is pushed into the FIFO on the next edge.
- Response latency: a read accepted at edge T0 has RspValid_SO=1 in the cycle after edge T0+RAM_LATENCY, i.e. response latency = RAM_LATENCY+1 cycles.
- Response FIFO:
  - First-word-fall-through; RspValid_SO = ~empty; RspData_DO = head entry.
  - Push and pop in the same cycle are legal, including when the FIFO is full.
  - Overflow is impossible by credit construction (assertion on push while full without pop).
- Ordering: responses are returned strictly in read-acceptance order.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data, since RAM ordering is preserved.
- Throughput: with RESP_DEPTH >= RAM_LATENCY+1 and RspReady_SI held at 1, one request is accepted per cycle indefinitely.
- Reset mid-operation:
  - In-flight and buffered reads are discarded and never emerge; credits are restored.
  - RAM contents are untouched.
- RspValid_SO, once high, stays high with stable RspData_DO until pop.

Decomposition:
- Package sp_ram_pkg holds:
  - function cnt_width(depth) = $clog2(depth+1);
  - localparam MAX_RAM_LATENCY = 4.
- One sub-module: sp_ram_rsp_fifo, the FWFT FIFO with parameters DATA_WIDTH and DEPTH, ports push/pop/full/empty, synchronous active-low reset.
- Credit counter and latency pipe stay in the top module.

Test Plan (RAM_LATENCY=1, RESP_DEPTH=2 unless stated; bench RAM model with matching latency):
1. Hold Rst_RBI=0 for 2 edges with ReqValid_SI=1 -> ReqReady_SO=0, RamCSel_SO=0, RspValid_SO=0. After release -> ReqReady_SO=1 in the next cycle.
2. Write 0xDEADBEEF @0x005, then read @0x005 next cycle -> exactly 2 RamCSel_SO pulses; RspValid_SO=1 with RspData_DO=0xDEADBEEF 2 cycles after the read accept; no response for the write.
3. RspReady_SI=0, three back-to-back reads of 0x001/0x002/0x003 (preloaded 0x11/0x22/0x33) -> two accepted, then ReqReady_SO=0. Raise RspReady_SI -> third accepted in the same cycle as the first pop; outputs 0x11, 0x22, 0x33 in order.
4. 8 consecutive reads of 0x000..0x007 with RspReady_SI=1 -> ReqReady_SO never drops; 8 responses on 8 consecutive cycles, in order.
5. Two reads in flight, Rst_RBI=0 for 1 edge -> no response ever appears. After reset, a read @0x005 returns 0xDEADBEEF with credits back at 2.
6. RAM_LATENCY=2, RESP_DEPTH=3: single read @0x00A (0xCAFE0001) -> response 3 cycles after accept. 10 streaming reads -> no stall.
